// File: rtl/hour_counter_12_24.sv
`default_nettype none
// ============================================================================
// Module      : hour_counter_12_24
// Description : BCD 24 h hour counter with 12/24 h display, AM/PM flag,
//               edge-triggered manual set with auto-repeat and day pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module hour_counter_12_24 #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int RESET_HOUR    = 0,
    parameter int TMR_W         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_h,
    input  logic       up,
    input  logic       down,
    input  logic       mode_24,
    output logic [1:0] hour_ten,
    output logic [3:0] hour_unit,
    output logic [1:0] disp_ten,
    output logic [3:0] disp_unit,
    output logic       pm,
    output logic       pulse_day,
    output logic       set_active
);

    localparam logic [1:0]       c_RST_TEN    = 2'(RESET_HOUR / 10);
    localparam logic [3:0]       c_RST_UNIT   = 4'(RESET_HOUR % 10);
    localparam logic [TMR_W-1:0] c_DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] c_PER_LAST   = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE    = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             r_dir_up;
    logic             w_dir_nxt;
    logic             r_req_up_d;
    logic             r_req_dn_d;
    logic             w_clr_hist;
    logic [1:0]       r_hour_ten;
    logic [3:0]       r_hour_unit;
    logic             r_pulse_day;

    logic w_req_up;
    logic w_req_dn;
    logic w_edge_up;
    logic w_edge_dn;
    logic w_hold;
    logic w_step_up;
    logic w_step_dn;

    logic [1:0] w_inc_ten;
    logic [3:0] w_inc_unit;
    logic [1:0] w_dec_ten;
    logic [3:0] w_dec_unit;

    assign w_req_up  = up & ~down;
    assign w_req_dn  = down & ~up;
    assign w_edge_up = w_req_up & ~r_req_up_d;
    assign w_edge_dn = w_req_dn & ~r_req_dn_d;
    assign w_hold    = r_dir_up ? w_req_up : w_req_dn;

    // Set FSM: first step on the press edge, then delay, then periodic repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_dir_nxt   = r_dir_up;
        w_step_up   = 1'b0;
        w_step_dn   = 1'b0;
        w_clr_hist  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge_up || w_edge_dn) begin
                    w_step_up   = w_edge_up;
                    w_step_dn   = w_edge_dn;
                    w_dir_nxt   = w_edge_up;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!w_hold) begin
                    // Forget history so a reversed direction re-arms as a fresh edge.
                    w_clr_hist  = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_tmr == ((r_state == S_DELAY) ? c_DELAY_LAST : c_PER_LAST)) begin
                    w_step_up   = r_dir_up;
                    w_step_dn   = ~r_dir_up;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_tmr_nxt   = r_tmr + c_TMR_ONE;
                end
            end
            default: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_inc_ten  = r_hour_ten;
        w_inc_unit = r_hour_unit + 4'd1;
        if (r_hour_ten == 2'd2 && r_hour_unit == 4'd3) begin
            w_inc_ten  = 2'd0;
            w_inc_unit = 4'd0;
        end else if (r_hour_unit == 4'd9) begin
            w_inc_ten  = r_hour_ten + 2'd1;
            w_inc_unit = 4'd0;
        end
    end

    always_comb begin
        w_dec_ten  = r_hour_ten;
        w_dec_unit = r_hour_unit - 4'd1;
        if (r_hour_ten == 2'd0 && r_hour_unit == 4'd0) begin
            w_dec_ten  = 2'd2;
            w_dec_unit = 4'd3;
        end else if (r_hour_unit == 4'd0) begin
            w_dec_ten  = r_hour_ten - 2'd1;
            w_dec_unit = 4'd9;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_dir_up    <= 1'b0;
            r_req_up_d  <= 1'b0;
            r_req_dn_d  <= 1'b0;
            r_hour_ten  <= c_RST_TEN;
            r_hour_unit <= c_RST_UNIT;
            r_pulse_day <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_dir_up    <= w_dir_nxt;
            r_req_up_d  <= w_req_up & ~w_clr_hist;
            r_req_dn_d  <= w_req_dn & ~w_clr_hist;
            r_pulse_day <= en_h && (r_hour_ten == 2'd2) && (r_hour_unit == 4'd3);
            // The minute-stage strobe wins; a coincident manual step is dropped.
            if (en_h || w_step_up) begin
                r_hour_ten  <= w_inc_ten;
                r_hour_unit <= w_inc_unit;
            end else if (w_step_dn) begin
                r_hour_ten  <= w_dec_ten;
                r_hour_unit <= w_dec_unit;
            end
        end
    end

    always_comb begin
        disp_ten  = r_hour_ten;
        disp_unit = r_hour_unit;
        if (!mode_24) begin
            if (r_hour_ten == 2'd0 && r_hour_unit == 4'd0) begin
                disp_ten  = 2'd1;
                disp_unit = 4'd2;
            end else if (r_hour_ten == 2'd1 && r_hour_unit > 4'd2) begin
                disp_ten  = 2'd0;
                disp_unit = r_hour_unit - 4'd2;
            end else if (r_hour_ten == 2'd2 && r_hour_unit < 4'd2) begin
                disp_ten  = 2'd0;
                disp_unit = r_hour_unit + 4'd8;
            end else if (r_hour_ten == 2'd2) begin
                disp_ten  = 2'd1;
                disp_unit = r_hour_unit - 4'd2;
            end
        end
    end

    assign pm         = (r_hour_ten == 2'd2) || (r_hour_ten == 2'd1 && r_hour_unit >= 4'd2);
    assign hour_ten   = r_hour_ten;
    assign hour_unit  = r_hour_unit;
    assign pulse_day  = r_pulse_day;
    assign set_active = w_req_up | w_req_dn;

endmodule
`default_nettype wire

// File: tb/tb_hour_counter_12_24.sv
`default_nettype none
// ============================================================================
// Module      : tb_hour_counter_12_24
// Description : Directed scoreboard bench for hour_counter_12_24.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hour_counter_12_24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_h = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       mode_24 = 1'b1;
    logic [1:0] hour_ten;
    logic [3:0] hour_unit;
    logic [1:0] disp_ten;
    logic [3:0] disp_unit;
    logic       pm;
    logic       pulse_day;
    logic       set_active;

    hour_counter_12_24 #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3),
        .RESET_HOUR    (0),
        .TMR_W         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_h       (en_h),
        .up         (up),
        .down       (down),
        .mode_24    (mode_24),
        .hour_ten   (hour_ten),
        .hour_unit  (hour_unit),
        .disp_ten   (disp_ten),
        .disp_unit  (disp_unit),
        .pm         (pm),
        .pulse_day  (pulse_day),
        .set_active (set_active)
    );

    always #5 clk = ~clk;

    wire [7:0] w_hour = {2'b00, hour_ten, hour_unit};
    wire [7:0] w_disp = {2'b00, disp_ten, disp_unit};

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    int sweep_h  [6] = '{0, 1, 11, 12, 13, 23};
    int sweep_d  [6] = '{12, 1, 11, 12, 1, 11};
    int sweep_pm [6] = '{0, 0, 0, 1, 1, 1};

    function automatic logic [7:0] bcd(input int h);
        return 8'(((h / 10) << 4) | (h % 10));
    endfunction

    task automatic push(input string tag, input logic [7:0] e);
        sb_t item;
        item.tag = tag;
        item.exp = e;
        sb_q.push_back(item);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        sb_t item;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            item = sb_q.pop_front();
            assert (obs === item.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en_h = 1'b0;
        up   = 1'b0;
        down = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic goto_hour(input int h);
        do_reset();
        for (int i = 0; i < h; i++) begin
            en_h = 1'b1;
            tick();
        end
        en_h = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        do_reset();
        #1;
        push("reset_hour", 8'h00);       pop_check(w_hour);
        push("reset_pulse", 8'h00);      pop_check({7'b0, pulse_day});
        push("reset_set_active", 8'h00); pop_check({7'b0, set_active});
        push("reset_disp24", 8'h00);     pop_check(w_disp);

        // Full day of minute-stage strobes
        for (int i = 1; i <= 24; i++) begin
            en_h = 1'b1;
            push("en_h_hour", bcd(i % 24));
            push("en_h_pulse", (i == 24) ? 8'h01 : 8'h00);
            push("en_h_no_x", 8'h00);
            tick();
            en_h = 1'b0;
            pop_check(w_hour);
            pop_check({7'b0, pulse_day});
            pop_check({7'b0, $isunknown({hour_ten, hour_unit, disp_ten, disp_unit, pm, pulse_day, set_active})});
            push("pulse_one_cycle", 8'h00);
            tick();
            pop_check({7'b0, pulse_day});
        end

        // 12 h display sweep, then back to 24 h
        for (int i = 0; i < 6; i++) begin
            mode_24 = 1'b0;
            goto_hour(sweep_h[i]);
            #1;
            push("disp12", bcd(sweep_d[i]));     pop_check(w_disp);
            push("pm", 8'(sweep_pm[i]));         pop_check({7'b0, pm});
            mode_24 = 1'b1;
            #1;
            push("disp24", bcd(sweep_h[i]));     pop_check(w_disp);
            push("mode_keeps_hour", bcd(sweep_h[i])); pop_check(w_hour);
        end

        // Single manual steps
        goto_hour(0);
        down = 1'b1;
        #1;
        push("set_active_down", 8'h01); pop_check({7'b0, set_active});
        push("down_00", bcd(23));
        tick();
        down = 1'b0;
        pop_check(w_hour);
        push("down_no_pulse", 8'h00); pop_check({7'b0, pulse_day});
        push("down_00_hold", bcd(23));
        tick();
        pop_check(w_hour);

        goto_hour(20);
        down = 1'b1;
        push("down_20", bcd(19));
        tick();
        down = 1'b0;
        pop_check(w_hour);

        goto_hour(9);
        up = 1'b1;
        push("up_09", bcd(10));
        tick();
        up = 1'b0;
        pop_check(w_hour);

        // Hold up: step on press, after the delay, then every period
        goto_hour(0);
        up = 1'b1;
        n = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k == 0 || (k >= 8 && (k - 8) % 3 == 0)) n++;
            push("repeat_hold", bcd(n));
            tick();
            pop_check(w_hour);
        end
        up = 1'b0;
        repeat (6) tick();
        push("repeat_release", bcd(6)); pop_check(w_hour);

        // Both buttons: no request; releasing one gives a fresh edge
        up   = 1'b1;
        down = 1'b1;
        #1;
        push("both_set_active", 8'h00); pop_check({7'b0, set_active});
        repeat (20) tick();
        push("both_hour", bcd(6)); pop_check(w_hour);
        down = 1'b0;
        #1;
        push("up_only_set_active", 8'h01); pop_check({7'b0, set_active});
        push("up_after_both", bcd(7));
        tick();
        pop_check(w_hour);
        up = 1'b0;
        push("up_after_both_rel", bcd(7));
        tick();
        pop_check(w_hour);

        // en_h coincident with first manual step
        goto_hour(5);
        up   = 1'b1;
        en_h = 1'b1;
        push("en_h_beats_step", bcd(6));
        tick();
        en_h = 1'b0;
        pop_check(w_hour);
        for (int k = 1; k <= 9; k++) begin
            push("coinc_delay", (k >= 8) ? bcd(7) : bcd(6));
            tick();
            pop_check(w_hour);
        end

        // Asynchronous reset mid-repeat with the button still held
        #2;
        rst_n = 1'b0;
        #1;
        push("async_reset_hour", 8'h00);   pop_check(w_hour);
        push("async_reset_pulse", 8'h00);  pop_check({7'b0, pulse_day});
        @(negedge clk);
        rst_n = 1'b1;
        push("post_reset_edge", bcd(1));
        tick();
        pop_check(w_hour);
        for (int k = 1; k <= 8; k++) begin
            push("post_reset_delay", (k == 8) ? bcd(2) : bcd(1));
            tick();
            pop_check(w_hour);
        end
        up = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hour_counter_12_24.md
Name: hour_counter_12_24

Overview:
- Next-generation hour counter for the century clock. Keeps hours in 24 h BCD internally and drives display digits in either 12 h or 24 h format, selectable at run time, with an AM/PM flag.
- Adds edge-detected manual set with hold-to-auto-repeat, and a registered day-rollover pulse for the day/date stage.
- Sits between the minute counter (source of en_h) and the day counter (sink of pulse_day).

Parameters:
- REPEAT_DELAY, 25000000: clk cycles a button must be held after the first step before auto-repeat starts (0.5 s at 50 MHz); legal values ≥ 2.
- REPEAT_PERIOD, 5000000: clk cycles between auto-repeat steps (0.1 s at 50 MHz); legal values ≥ 1.
- RESET_HOUR, 0: hour loaded at reset, 24 h value 0..23.
- TMR_W, 25: repeat timer width; must satisfy 2^TMR_W > max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- en_h  in  1  one-cycle advance strobe from the minute stage.
- up  in  1  set-up button level (already synchronised and debounced).
- down  in  1  set-down button level (already synchronised and debounced).
- mode_24  in  1  1 = 24 h display, 0 = 12 h display.
- hour_ten  out  2  internal 24 h tens digit, 0..2.
- hour_unit  out  4  internal 24 h units digit, 0..9.
- disp_ten  out  2  display tens digit in the selected mode.
- disp_unit  out  4  display units digit in the selected mode.
- pm  out  1  1 when the internal hour is ≥ 12, in both modes.
- pulse_day  out  1  one-cycle pulse on a 23→00 rollover caused by en_h.
- set_active  out  1  1 while up XOR down is held.

Behaviour:
- Reset: hour_ten/hour_unit = BCD(RESET_HOUR), pulse_day = 0, FSM = IDLE, timer = 0, up/down history regs = 0.
- Internal state is registered. Only legal BCD 00..23 is reachable.
- Increment: 23→00, x9→(x+1)0, else unit+1.
- Decrement: 00→23, x0→(x−1)9, else unit−1.
- en_h = 1: increment on that edge. If the prior hour was 23, pulse_day = 1 on the following cycle only. Otherwise pulse_day = 0.
- Manual steps never assert pulse_day.
- Priority: en_h beats manual. Any step requested in an en_h cycle is dropped; the FSM and timer still advance normally.
- Button request: req_up = up & ~down, req_dn = down & ~up. Both or neither pressed = no request.
- Set FSM states:
  - IDLE: on a rising edge of the request (request active now, inactive last cycle), take one step that edge, load timer = 0, go to DELAY.
  - DELAY: timer increments each cycle. When the timer reaches REPEAT_DELAY−1, take one step, reset timer, go to REPEAT.
  - REPEAT: timer increments. When it reaches REPEAT_PERIOD−1, take one step and reset timer.
  - DELAY/REPEAT → IDLE the cycle the request drops or changes direction, with no step that cycle.
  - A direction change then counts as a new rising edge on the next cycle.
- Step latency: step is visible on the outputs 1 cycle after the first sampled-high request cycle.
- Display, combinational from the registered state, 0 latency:
  - mode_24 = 1: disp = hour.
  - mode_24 = 0: h = 0 → 12; 1..12 → h; 13..23 → h−12.
- mode_24 toggling changes only the display; internal state and FSM are unaffected.
- set_active = req_up | req_dn (combinational).
- Reset mid-hold: FSM returns to IDLE. If the button is still held at release of reset, that counts as a rising edge one cycle after reset deasserts.

Test Plan (REPEAT_DELAY = 8, REPEAT_PERIOD = 3, RESET_HOUR = 0):
- Reset, then 24 en_h pulses, 1 cycle apart → hour 01,02..23,00. pulse_day high exactly once, one cycle after the 23→00 edge. No X on any output.
- mode_24 = 0, sweep hours 00, 01, 11, 12, 13, 23 → disp/pm = 12/0, 01/0, 11/0, 12/1, 01/1, 11/1. Set mode_24 = 1 → disp equals hour.
- Hour 00, down held 1 cycle → 23, no pulse_day. Hour 20, down once → 19. Hour 09, up once → 10.
- up held 20 cycles from hour 00 → steps 1 cycle after press, then +8, +11, +14, +17, +20 cycles → final hour 06. Release → no further steps.
- up and down held together 20 cycles → hour unchanged, set_active = 0. Then release down only → one step up on the next edge.
- en_h coincident with the first up step at hour 05 → hour 06 only (step dropped). Assert rst_n = 0 mid-repeat → hour resets to 00 asynchronously and FSM = IDLE.
